// File: rtl/node_arb_if.sv
// Bundle of requester-side and shared-node-side signals for node_arb.
// The arbiter attaches through the slave modport; the requesters and node model use master.
interface node_arb_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 16
);
    logic [NREQ-1:0]     REQ;
    logic [NREQ*3*W-1:0] OPS;
    logic [NREQ-1:0]     GNT;
    logic [NREQ-1:0]     DONE;
    logic [W-1:0]        RES;
    logic                ERR;
    logic                BUSY;
    logic                NODE_ST;
    logic                NODE_RD;
    logic [W-1:0]        NODE_RES;
    logic [W-1:0]        NODE_IN0;
    logic [W-1:0]        NODE_IN1;
    logic [W-1:0]        NODE_IN2;

    modport slave (
        input  REQ, OPS, NODE_RD, NODE_RES,
        output GNT, DONE, RES, ERR, BUSY, NODE_ST, NODE_IN0, NODE_IN1, NODE_IN2
    );

    modport master (
        output REQ, OPS, NODE_RD, NODE_RES,
        input  GNT, DONE, RES, ERR, BUSY, NODE_ST, NODE_IN0, NODE_IN1, NODE_IN2
    );
endinterface

// File: rtl/node_arb.sv
// Round-robin arbiter that shares one evaluation node between NREQ requesters.
// Optional per-phase handshake timeout is enabled by defining NODE_ARB_TIMEOUT_EN.
module node_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    node_arb_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned IDX_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WLOW   = 3'd2,
        WHIGH  = 3'd3,
        REL    = 3'd4
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             any_req;

`ifdef NODE_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT < 256) ? 8 : 16;
    logic [CNT_W-1:0] cnt;
    logic             to_hit;

    assign to_hit = (cnt == CNT_W'(TIMEOUT - 1));
`endif

    // Pick the first request at or after the pointer; scanning downward lets the nearest one win.
    always_comb begin
        sel     = ptr;
        any_req = 1'b0;
        idx     = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + IDX_W'(i);
            if (idx >= IDX_W'(NREQ)) begin
                idx = idx - IDX_W'(NREQ);
            end
            if (bus.REQ[idx[PTR_W-1:0]]) begin
                sel     = idx[PTR_W-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            ptr          <= '0;
            gidx         <= '0;
            bus.GNT      <= '0;
            bus.DONE     <= '0;
            bus.RES      <= '0;
            bus.ERR      <= 1'b0;
            bus.BUSY     <= 1'b0;
            bus.NODE_ST  <= 1'b0;
            bus.NODE_IN0 <= '0;
            bus.NODE_IN1 <= '0;
            bus.NODE_IN2 <= '0;
`ifdef NODE_ARB_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            bus.DONE <= '0;
            bus.ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gidx         <= sel;
                        bus.GNT      <= NREQ'(1) << sel;
                        bus.NODE_IN0 <= bus.OPS[W*(3*32'(sel)+0) +: W];
                        bus.NODE_IN1 <= bus.OPS[W*(3*32'(sel)+1) +: W];
                        bus.NODE_IN2 <= bus.OPS[W*(3*32'(sel)+2) +: W];
                        bus.BUSY     <= 1'b1;
                        state        <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    bus.NODE_ST <= 1'b1;
                    state       <= WLOW;
`ifdef NODE_ARB_TIMEOUT_EN
                    cnt         <= '0;
`endif
                end
                WLOW: begin
                    if (!bus.NODE_RD) begin
                        state <= WHIGH;
`ifdef NODE_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
`ifdef NODE_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        bus.NODE_ST <= 1'b0;
                        bus.DONE    <= NREQ'(1) << gidx;
                        bus.ERR     <= 1'b1;
                        state       <= REL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                WHIGH: begin
                    if (bus.NODE_RD) begin
                        bus.RES     <= bus.NODE_RES;
                        bus.DONE    <= NREQ'(1) << gidx;
                        bus.NODE_ST <= 1'b0;
                        state       <= REL;
                    end
`ifdef NODE_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        bus.NODE_ST <= 1'b0;
                        bus.DONE    <= NREQ'(1) << gidx;
                        bus.ERR     <= 1'b1;
                        state       <= REL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                REL: begin
                    // Served requester drops to lowest priority; this state also keeps NODE_ST low between launches.
                    bus.GNT  <= '0;
                    bus.BUSY <= 1'b0;
                    ptr      <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/node_arb.md
# node_arb

Round-robin arbiter and sequencer that shares one tree-parser evaluation node between `NREQ` requesters. It grants one requester at a time and registers that requester's three operands onto the node inputs. It then drives the node's start/ready handshake (`ST` rising edge starts, `RD` low→high completes), captures the result and returns it with a one-cycle done strobe. It sits between several parent nodes and a single shared (expensive) child node.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `W`, 16: operand/result width.
- `TIMEOUT`, 255: max cycles per handshake phase (used only with `NODE_ARB_TIMEOUT_EN`).

Ports (one clock; reset is asynchronous and active-high):
- `CLK`  in  1  clock, all state on posedge.
- `RST`  in  1  asynchronous active-high reset.
- `REQ`  in  NREQ  request per requester; level, held until its `DONE`.
- `OPS`  in  NREQ*3*W  operands; slice `[(3i+k)*W +: W]` = operand k of requester i.
- `GNT`  out  NREQ  one-hot grant; high from grant until release.
- `DONE`  out  NREQ  one-cycle pulse to the granted requester when `RES` is valid.
- `RES`  out  W  last captured node result; held until next capture.
- `ERR`  out  1  pulses with `DONE` on timeout abort (0 when feature off).
- `BUSY`  out  1  high in every state except IDLE.
- `NODE_ST`  out  1  start to shared node.
- `NODE_RD`  in  1  ready from shared node (1 = idle/done).
- `NODE_IN0..NODE_IN2`  out  W each  registered operands to node.

## Operation
- Reset values: `GNT`=0, `DONE`=0, `RES`=0, `ERR`=0, `BUSY`=0, `NODE_ST`=0, `NODE_IN*`=0, state IDLE, RR pointer=0.
- FSM states are IDLE, LAUNCH, WLOW, WHIGH and REL.
- IDLE: if any `REQ` is set, select the first set bit at or after the pointer (wrapping). Set `GNT[g]` and latch its three operands into `NODE_IN0..2`. Go to LAUNCH. With no request, stay.
- LAUNCH: `NODE_ST`←1. Go to WLOW.
- WLOW: wait for `NODE_RD`=0, then go to WHIGH.
- WHIGH: wait for `NODE_RD`=1, then `RES`←`NODE_RES`, `DONE[g]`←1 (one cycle) and `NODE_ST`←0. Go to REL.
- REL: `GNT`←0 and pointer←(g+1) mod `NREQ`. Go to IDLE.
- REL guarantees `NODE_ST` is low for ≥2 cycles between launches, so the node sees a fresh rising edge.
- Operands are sampled only at grant. Later `REQ`/`OPS` changes do not affect the transaction in flight.
- A `REQ` withdrawn mid-transaction does not abort it: `DONE` still pulses and the result is discarded by the requester.
- A `REQ` still high after `DONE` is treated as a new request. It is re-granted only when its turn comes in the rotation.
- `NODE_RD` already low in IDLE is ignored; the handshake starts only from LAUNCH.

## Timing
- Grant edge = E0. `NODE_ST` rises at E1.
- With a node that drops `RD` on the edge it sees `ST` rise and raises it two edges later:
  - `DONE` is high after E5.
  - `GNT` clears at E6.
  - The next grant is possible at E7.
- Minimum request-to-next-grant period is 7 cycles with this node.
- Reset mid-operation: all outputs return to reset values asynchronously and `NODE_ST` drops immediately. The node is re-launched cleanly after reset.
- Simultaneous `REQ` bits: the round-robin pointer decides. After serving g, g has the lowest priority.

## Configuration
- `NODE_ARB_TIMEOUT_EN` defined:
  - An 8..16-bit phase counter runs in WLOW and WHIGH and clears on each phase entry.
  - If it reaches `TIMEOUT`, the FSM forces `NODE_ST`←0, pulses `DONE[g]` and `ERR` together and leaves `RES` unchanged. It then goes to REL.
- Not defined: no counter. WLOW/WHIGH wait indefinitely and `ERR` is tied 0.

## Test plan
- Single request: `REQ`=0001, ops (5,7,9), model node returns IN2. Expect `GNT`=0001 at E0, `NODE_IN`=(5,7,9), `NODE_ST` rises at E1, `DONE`=0001 pulse after E5, `RES`=9.
- All four `REQ` high continuously, each with distinct IN2 (1,2,3,4). Expect grants in order 0,1,2,3,0 and `RES` 1,2,3,4 with matching `DONE` bits. There must be no double grant and `NODE_ST` low for ≥2 cycles between launches.
- Starvation check: `REQ[0]` held and `REQ[2]` pulsed. Expect alternating service 0,2,0 and never 0,0 while 2 is pending.
- `RST` asserted in WHIGH. Expect immediate `NODE_ST`=0, `GNT`=0, `RES`=0 and no `DONE`. After release, a new request completes normally.
- `OPS` changed and `REQ` dropped one cycle after grant. Expect the node to receive the original operands and `DONE` to pulse anyway.
- With `NODE_ARB_TIMEOUT_EN`, `TIMEOUT`=10, node stuck with `RD`=1. Expect `DONE` and `ERR` pulse 10 cycles after WLOW entry, `RES` unchanged, and the next requester granted afterward.
